piso_tx: RTL and testbench

Parallel-in, serial-out transmitter. It accepts a WIDTH-bit word through a valid/ready load handshake and presents the word one bit per enabled clock on a serial output. The serial line is paired with a frame-valid flag and an end-of-word pulse. The block is the sending end of the team's serial capture path: its sout/sout_valid pair drives the downstream latch-based serial capture logic bit by bit.

---
 rtl/piso_tx.sv | 104 ++++++++++
 tb/tb_piso_tx.sv | 187 ++++++++++++++++++
 2 files changed

// File: rtl/piso_tx.sv
// Parallel-in, serial-out transmitter: takes a word on a valid/ready load and
// shifts it out one bit per enabled clock, framed by sout_valid and a done pulse.
module piso_tx #(
    parameter int WIDTH     = 8,
    parameter bit MSB_FIRST = 1'b1
) (
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic             e_i,
    input  logic             load_valid_i,
    output logic             load_ready_o,
    input  logic [WIDTH-1:0] din_i,
    output logic             sout_o,
    output logic             sout_valid_o,
    output logic             done_o,
    output logic             busy_o
);

    localparam int            CW   = $clog2(WIDTH);
    localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SHIFT = 2'd1,
        DONE  = 2'd2
    } state_t;

    state_t           state_q;
    logic [WIDTH-1:0] shreg_q;
    logic [WIDTH-1:0] shreg_d;
    logic [CW-1:0]    cnt_q;
    logic             sout_q;
    logic             valid_q;
    logic             done_q;
    logic             busy_q;

    function automatic logic out_bit(input logic [WIDTH-1:0] v);
        return MSB_FIRST ? v[WIDTH-1] : v[0];
    endfunction

    // Register moves toward whichever end feeds sout; vacated bits fill with zero.
    always_comb begin
        shreg_d = MSB_FIRST ? (shreg_q << 1) : (shreg_q >> 1);
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q <= IDLE;
            shreg_q <= '0;
            cnt_q   <= '0;
            sout_q  <= 1'b0;
            valid_q <= 1'b0;
            done_q  <= 1'b0;
            busy_q  <= 1'b0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (load_valid_i) begin
                        state_q <= SHIFT;
                        shreg_q <= din_i;
                        cnt_q   <= '0;
                        sout_q  <= out_bit(din_i);
                        valid_q <= 1'b1;
                        busy_q  <= 1'b1;
                    end
                end
                SHIFT: begin
                    if (e_i) begin
                        if (cnt_q == LAST) begin
                            state_q <= DONE;
                            sout_q  <= 1'b0;
                            valid_q <= 1'b0;
                            done_q  <= 1'b1;
                        end else begin
                            shreg_q <= shreg_d;
                            cnt_q   <= cnt_q + 1'b1;
                            sout_q  <= out_bit(shreg_d);
                        end
                    end
                end
                DONE: begin
                    state_q <= IDLE;
                    done_q  <= 1'b0;
                    busy_q  <= 1'b0;
                end
                default: begin
                    state_q <= IDLE;
                    sout_q  <= 1'b0;
                    valid_q <= 1'b0;
                    done_q  <= 1'b0;
                    busy_q  <= 1'b0;
                end
            endcase
        end
    end

    // Reset must block acceptance immediately, hence the only combinational input path.
    assign load_ready_o = (state_q == IDLE) && !rst_i;
    assign sout_o       = sout_q;
    assign sout_valid_o = valid_q;
    assign done_o       = done_q;
    assign busy_o       = busy_q;

endmodule

// File: tb/tb_piso_tx.sv
// Directed bench for piso_tx: MSB-first, LSB-first and WIDTH=2 instances
// driven from one linear sequence with hand-computed expected bits.
module tb_piso_tx;

    logic clk = 1'b0;
    logic rst = 1'b1;
    logic e   = 1'b1;

    logic       lvA = 1'b0, lvB = 1'b0, lvC = 1'b0;
    logic [7:0] dinA = '0, dinB = '0;
    logic [1:0] dinC = '0;
    logic       rdyA, soA, svA, dnA, bzA;
    logic       rdyB, soB, svB, dnB, bzB;
    logic       rdyC, soC, svC, dnC, bzC;

    int errors = 0;
    int checks = 0;

    always #5 clk = ~clk;

    piso_tx #(.WIDTH(8), .MSB_FIRST(1'b1)) dutA (
        .clk_i(clk), .rst_i(rst), .e_i(e), .load_valid_i(lvA), .load_ready_o(rdyA),
        .din_i(dinA), .sout_o(soA), .sout_valid_o(svA), .done_o(dnA), .busy_o(bzA)
    );
    piso_tx #(.WIDTH(8), .MSB_FIRST(1'b0)) dutB (
        .clk_i(clk), .rst_i(rst), .e_i(e), .load_valid_i(lvB), .load_ready_o(rdyB),
        .din_i(dinB), .sout_o(soB), .sout_valid_o(svB), .done_o(dnB), .busy_o(bzB)
    );
    piso_tx #(.WIDTH(2), .MSB_FIRST(1'b1)) dutC (
        .clk_i(clk), .rst_i(rst), .e_i(e), .load_valid_i(lvC), .load_ready_o(rdyC),
        .din_i(dinC), .sout_o(soC), .sout_valid_o(svC), .done_o(dnC), .busy_o(bzC)
    );

    task automatic chk(input string tag, input logic obs, input logic exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("[TB] FAIL %s: observed=%b expected=%b", tag, obs, exp);
        end
    endtask

    // Advance one edge and sample well after it.
    task automatic tick();
        @(posedge clk);
        #2;
    endtask

    logic [7:0] v;
    logic [1:0] w;

    initial begin
        // Reset state
        tick(); tick();
        chk("rst_ready", rdyA, 1'b0);
        chk("rst_valid", svA, 1'b0);
        chk("rst_busy",  bzA, 1'b0);
        chk("rst_done",  dnA, 1'b0);
        chk("rst_sout",  soA, 1'b0);
        rst = 1'b0;
        #1;
        chk("post_rst_ready", rdyA, 1'b1);

        // A5 MSB-first with e held high
        v = 8'hA5; dinA = v; lvA = 1'b1; e = 1'b1;
        tick();
        lvA = 1'b0; dinA = 8'h00;
        for (int k = 0; k < 8; k++) begin
            chk($sformatf("a5_bit%0d", k), soA, v[7-k]);
            chk($sformatf("a5_valid%0d", k), svA, 1'b1);
            chk($sformatf("a5_done%0d", k), dnA, 1'b0);
            tick();
        end
        chk("a5_done", dnA, 1'b1);
        chk("a5_done_valid", svA, 1'b0);
        chk("a5_done_busy", bzA, 1'b1);
        chk("a5_done_ready", rdyA, 1'b0);
        tick();
        chk("a5_done_off", dnA, 1'b0);
        chk("a5_ready_back", rdyA, 1'b1);
        chk("a5_busy_off", bzA, 1'b0);

        // 01 LSB-first
        v = 8'h01; dinB = v; lvB = 1'b1;
        tick();
        lvB = 1'b0;
        for (int k = 0; k < 8; k++) begin
            chk($sformatf("lsb_bit%0d", k), soB, v[k]);
            chk($sformatf("lsb_valid%0d", k), svB, 1'b1);
            tick();
        end
        chk("lsb_done", dnB, 1'b1);
        tick();
        chk("lsb_done_off", dnB, 1'b0);

        // F0 with e toggling: each bit held two cycles
        v = 8'hF0; dinA = v; lvA = 1'b1;
        tick();
        lvA = 1'b0;
        for (int i = 0; i < 16; i++) begin
            e = (i % 2 == 1);
            chk($sformatf("tog_bit%0d", i), soA, v[7-(i/2)]);
            chk($sformatf("tog_valid%0d", i), svA, 1'b1);
            tick();
        end
        e = 1'b1;
        chk("tog_done", dnA, 1'b1);
        tick();
        chk("tog_done_off", dnA, 1'b0);

        // Back-to-back FF then 00 with load_valid held high
        dinA = 8'hFF; lvA = 1'b1;
        tick();
        dinA = 8'h00;
        for (int k = 0; k < 8; k++) begin
            chk($sformatf("b2b_ff_bit%0d", k), soA, 1'b1);
            chk($sformatf("b2b_ff_ready%0d", k), rdyA, 1'b0);
            tick();
        end
        chk("b2b_done", dnA, 1'b1);
        tick();
        chk("b2b_idle_ready", rdyA, 1'b1);
        chk("b2b_idle_valid", svA, 1'b0);
        tick();
        lvA = 1'b0;
        for (int k = 0; k < 8; k++) begin
            chk($sformatf("b2b_00_bit%0d", k), soA, 1'b0);
            chk($sformatf("b2b_00_valid%0d", k), svA, 1'b1);
            tick();
        end
        chk("b2b2_done", dnA, 1'b1);
        tick();
        chk("b2b2_ready", rdyA, 1'b1);

        // Reset during bit 3 of 3C, then 81
        v = 8'h3C; dinA = v; lvA = 1'b1;
        tick();
        lvA = 1'b0;
        for (int k = 0; k < 3; k++) begin
            chk($sformatf("3c_bit%0d", k), soA, v[7-k]);
            tick();
        end
        chk("3c_bit3", soA, v[4]);
        rst = 1'b1;
        tick();
        chk("midrst_sout", soA, 1'b0);
        chk("midrst_valid", svA, 1'b0);
        chk("midrst_busy", bzA, 1'b0);
        chk("midrst_ready", rdyA, 1'b0);
        chk("midrst_done", dnA, 1'b0);
        rst = 1'b0;
        #1;
        chk("midrst_ready_back", rdyA, 1'b1);
        v = 8'h81; dinA = v; lvA = 1'b1;
        tick();
        lvA = 1'b0;
        chk("81_no_done", dnA, 1'b0);
        for (int k = 0; k < 8; k++) begin
            chk($sformatf("81_bit%0d", k), soA, v[7-k]);
            chk($sformatf("81_valid%0d", k), svA, 1'b1);
            tick();
        end
        chk("81_done", dnA, 1'b1);
        tick();

        // WIDTH=2 instance
        w = 2'b10; dinC = w; lvC = 1'b1;
        tick();
        lvC = 1'b0;
        chk("w2_bit0", soC, 1'b1);
        chk("w2_valid0", svC, 1'b1);
        tick();
        chk("w2_bit1", soC, 1'b0);
        chk("w2_valid1", svC, 1'b1);
        chk("w2_nodone", dnC, 1'b0);
        tick();
        chk("w2_done", dnC, 1'b1);
        chk("w2_done_valid", svC, 1'b0);
        tick();
        chk("w2_done_off", dnC, 1'b0);
        chk("w2_ready", rdyC, 1'b1);
        chk("w2_busy_off", bzC, 1'b0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
